// File: rtl/sram_write_ctrl.sv
// rtl/sram_write_ctrl.sv - drains pixel FIFO entries into an asynchronous SRAM frame buffer
module sram_write_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 18,
    parameter int FRAME_PIXELS = 76800,
    parameter int WAIT_STATES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W:0]   fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame
);

    // Wide enough to count 0..WAIT_STATES; never narrower than one bit.
    localparam int WCNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr_cnt;
    logic [WCNT_W-1:0]   r_wait_cnt;

    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_dq_oe;
    logic                r_ce_n;
    logic                r_we_n;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_short_frame;

    logic                w_rd_en;
    logic                w_sof;
    logic                w_frame_last;
    logic                w_wait_last;
    logic [ADDR_W-1:0]   w_addr_base;

    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_dq_oe_nxt;
    logic                w_ce_n_nxt;
    logic                w_we_n_nxt;
    logic                w_busy_nxt;
    logic                w_frame_done_nxt;
    logic                w_short_frame_nxt;

    // The only combinational output: a fetch is issued straight from IDLE so the
    // FIFO data lands in the LOAD cycle.
    assign w_rd_en      = (r_state == S_IDLE) && en && !fifo_empty;
    assign w_sof        = fifo_dout[DATA_W];
    assign w_frame_last = (r_addr_cnt == ADDR_W'(FRAME_PIXELS - 1));
    assign w_wait_last  = (r_wait_cnt == WCNT_W'(WAIT_STATES));
    // A start-of-frame marker realigns the entry to the top of the frame buffer.
    assign w_addr_base  = w_sof ? '0 : r_addr_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one pass IDLE -> LOAD -> SETUP -> WRITE(xN) -> HOLD per pixel.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rd_en) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_WRITE;
            S_WRITE: if (w_wait_last) w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: values the registered strobes take while in the upcoming state.
    always_comb begin
        w_addr_nxt        = r_sram_addr;
        w_data_nxt        = r_data;
        w_dq_oe_nxt       = 1'b0;
        w_ce_n_nxt        = 1'b1;
        w_we_n_nxt        = 1'b1;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_frame_done_nxt  = 1'b0;
        w_short_frame_nxt = 1'b0;

        if (r_state == S_LOAD) begin
            w_addr_nxt        = w_addr_base;
            w_data_nxt        = fifo_dout[DATA_W-1:0];
            w_short_frame_nxt = w_sof && (r_addr_cnt != '0);
        end

        if (r_state == S_HOLD) begin
            w_frame_done_nxt = w_frame_last;
        end

        case (w_state_nxt)
            S_SETUP, S_HOLD: begin
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
            S_WRITE: begin
                w_ce_n_nxt  = 1'b0;
                w_dq_oe_nxt = 1'b1;
                w_we_n_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Output registers; reset drops every strobe immediately, abandoning any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sram_addr   <= '0;
            r_data        <= '0;
            r_dq_oe       <= 1'b0;
            r_ce_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
        end else begin
            r_sram_addr   <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_dq_oe       <= w_dq_oe_nxt;
            r_ce_n        <= w_ce_n_nxt;
            r_we_n        <= w_we_n_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_short_frame <= w_short_frame_nxt;
        end
    end

    // Frame address counter: cleared by sof, advanced after each completed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_cnt <= '0;
        end else if ((r_state == S_LOAD) && w_sof) begin
            r_addr_cnt <= '0;
        end else if (r_state == S_HOLD) begin
            r_addr_cnt <= w_frame_last ? '0 : r_addr_cnt + ADDR_W'(1);
        end
    end

    // Write-pulse counter: counts WRITE cycles so we_n stays low WAIT_STATES+1 cycles.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WRITE)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        end
    end

    assign fifo_rd_en  = w_rd_en;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_data;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = 1'b1;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign short_frame = r_short_frame;

endmodule
